// File: rtl/canvas_streamer_pkg.sv
// Shared constants and FSM encoding for the canvas-to-NN pixel streamer.
package canvas_streamer_pkg;

    localparam int CS_DIM     = 28;
    localparam int CS_PIX_W   = 16;
    localparam int CS_SAT_MAX = 2047;
    localparam int CS_IDX_W   = 10;
    localparam int CS_SUM_W   = 21;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_FINISH
    } state_t;

endpackage

// File: rtl/canvas_streamer_pix_clamp.sv
// Combinational saturation of a canvas pixel to the largest legal value.
module pix_clamp #(
    parameter int PIX_W   = 16,
    parameter int SAT_MAX = 2047
) (
    input  logic [PIX_W-1:0] pix_in,
    output logic [PIX_W-1:0] pix_out
);

    always_comb begin
        pix_out = (pix_in > PIX_W'(SAT_MAX)) ? PIX_W'(SAT_MAX) : pix_in;
    end

endmodule

// File: rtl/canvas_streamer.sv
// Streams a DIM x DIM canvas row-major over a valid/ready link with clamping,
// and reports the sum of the clamped pixels of each completed transfer.
module canvas_streamer
    import canvas_streamer_pkg::*;
#(
    parameter int DIM     = CS_DIM,
    parameter int PIX_W   = CS_PIX_W,
    parameter int SAT_MAX = CS_SAT_MAX
) (
    input  logic                                frame_clk,
    input  logic                                Reset,
    input  logic                                Start,
    input  logic                                Abort,
    input  logic [DIM-1:0][DIM-1:0][PIX_W-1:0]  canvas,
    input  logic                                pix_ready,
    output logic                                pix_valid,
    output logic [PIX_W-1:0]                    pix_data,
    output logic [CS_IDX_W-1:0]                 pix_index,
    output logic                                pix_last,
    output logic                                Busy,
    output logic                                Done,
    output logic [CS_SUM_W-1:0]                 pix_sum
);

    localparam int XY_W = $clog2(DIM);

    state_t                state_q, state_d;
    logic [XY_W-1:0]       x_q, x_d, y_q, y_d;
    logic [CS_IDX_W-1:0]   idx_q, idx_d;
    logic [CS_SUM_W-1:0]   sum_q, sum_d, pix_sum_q, pix_sum_d;
    logic                  valid_q, valid_d, last_q, last_d;
    logic                  busy_q, busy_d, done_q, done_d;
    logic [PIX_W-1:0]      pix_clamped;
    logic [CS_SUM_W-1:0]   sum_next;

    // The canvas is frozen while Busy, so a live mux at the registered
    // coordinates stays stable through downstream stalls.
    pix_clamp #(
        .PIX_W   (PIX_W),
        .SAT_MAX (SAT_MAX)
    ) u_clamp (
        .pix_in  (canvas[x_q][y_q]),
        .pix_out (pix_clamped)
    );

    assign sum_next = sum_q + CS_SUM_W'(pix_clamped);

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        idx_d     = idx_q;
        sum_d     = sum_q;
        pix_sum_d = pix_sum_q;
        valid_d   = valid_q;
        last_d    = last_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    state_d = ST_STREAM;
                    x_d     = '0;
                    y_d     = '0;
                    idx_d   = '0;
                    sum_d   = '0;
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            ST_STREAM: begin
                // Abort wins over a beat accepted on the same edge.
                if (Abort) begin
                    state_d = ST_IDLE;
                    x_d     = '0;
                    y_d     = '0;
                    idx_d   = '0;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    busy_d  = 1'b0;
                end else if (pix_ready) begin
                    sum_d = sum_next;
                    if (last_q) begin
                        state_d   = ST_FINISH;
                        pix_sum_d = sum_next;
                        valid_d   = 1'b0;
                        last_d    = 1'b0;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        if (x_q == XY_W'(DIM - 1)) begin
                            x_d = '0;
                            y_d = y_q + XY_W'(1);
                        end else begin
                            x_d = x_q + XY_W'(1);
                        end
                        idx_d  = idx_q + CS_IDX_W'(1);
                        last_d = (idx_q == CS_IDX_W'(DIM * DIM - 2));
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            idx_q     <= '0;
            sum_q     <= '0;
            pix_sum_q <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            idx_q     <= idx_d;
            sum_q     <= sum_d;
            pix_sum_q <= pix_sum_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign pix_valid = valid_q;
    assign pix_data  = pix_clamped;
    assign pix_index = idx_q;
    assign pix_last  = last_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign pix_sum   = pix_sum_q;

endmodule

// File: tb/tb_canvas_streamer.sv
// Scoreboard bench for canvas_streamer: stimulus queues expected beats,
// a negedge monitor pops and compares every accepted beat.
module tb_canvas_streamer;

    logic                         frame_clk;
    logic                         Reset;
    logic                         Start;
    logic                         Abort;
    logic [27:0][27:0][15:0]      canvas;
    logic                         pix_ready;
    logic                         pix_valid;
    logic [15:0]                  pix_data;
    logic [9:0]                   pix_index;
    logic                         pix_last;
    logic                         Busy;
    logic                         Done;
    logic [20:0]                  pix_sum;

    canvas_streamer dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .Start     (Start),
        .Abort     (Abort),
        .canvas    (canvas),
        .pix_ready (pix_ready),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .pix_index (pix_index),
        .pix_last  (pix_last),
        .Busy      (Busy),
        .Done      (Done),
        .pix_sum   (pix_sum)
    );

    typedef struct packed {
        logic [9:0]  idx;
        logic [15:0] data;
        logic        last;
    } beat_t;

    beat_t sb[$];
    int    vectors = 0;
    int    miscompares = 0;
    int    cyc = 0;
    int    done_cnt = 0;
    int    done_cyc = 0;
    int    last_acc_cyc = -10;
    int    start_cyc = 0;
    logic  held_vld = 1'b0;
    beat_t held;

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;
    always @(posedge frame_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] clampf(input logic [15:0] v);
        return (v > 16'd2047) ? 16'd2047 : v;
    endfunction

    task automatic tick;
        @(posedge frame_clk);
        #1;
    endtask

    task automatic push_beats(input int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.idx  = 10'(i);
            b.data = clampf(canvas[i % 28][i / 28]);
            b.last = (i == 783);
            sb.push_back(b);
        end
    endtask

    task automatic set_ramp;
        for (int x = 0; x < 28; x++)
            for (int y = 0; y < 28; y++)
                canvas[x][y] = 16'(y * 28 + x);
    endtask

    task automatic set_const(input logic [15:0] v);
        for (int x = 0; x < 28; x++)
            for (int y = 0; y < 28; y++)
                canvas[x][y] = v;
    endtask

    task automatic start_pulse;
        Start = 1'b1;
        tick;
        Start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done(input int exp_cnt);
        int n = 0;
        while (done_cnt < exp_cnt && n < 5000) begin
            tick;
            n++;
        end
        chk("done_count", done_cnt, exp_cnt);
        chk("sb_drained", sb.size(), 0);
    endtask

    task automatic wait_index(input logic [9:0] target, input string name);
        int n = 0;
        while (pix_index != target && n < 2000) begin
            tick;
            n++;
        end
        chk(name, pix_index, target);
    endtask

    // Monitor: pops on every accepted beat, checks stall stability and Done timing.
    always @(negedge frame_clk) begin
        if (Reset) begin
            held_vld = 1'b0;
        end else begin
            if (held_vld) begin
                chk("stall_valid", pix_valid, 1);
                chk("stall_index", pix_index, held.idx);
                chk("stall_data", pix_data, held.data);
                chk("stall_last", pix_last, held.last);
            end
            if (pix_valid && pix_ready && !Abort) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", pix_index, 10'h3ff);
                end else begin
                    beat_t e;
                    e = sb.pop_front();
                    chk("beat_index", pix_index, e.idx);
                    chk("beat_data", pix_data, e.data);
                    chk("beat_last", pix_last, e.last);
                    if (e.last) last_acc_cyc = cyc;
                end
            end
            if (Done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_after_last", cyc - last_acc_cyc, 1);
            end
            held_vld = pix_valid && !pix_ready && !Abort;
            held.idx  = pix_index;
            held.data = pix_data;
            held.last = pix_last;
        end
    end

    initial begin
        logic [10:0] pat;
        int          n;
        int          dc;
        pat = 11'b10010110011;
        Reset = 1'b1;
        Start = 1'b0;
        Abort = 1'b0;
        pix_ready = 1'b1;
        set_ramp();
        #2;
        chk("rst_valid", pix_valid, 0);
        chk("rst_index", pix_index, 0);
        chk("rst_last", pix_last, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_sum", pix_sum, 0);
        tick;
        tick;
        Reset = 1'b0;
        tick;

        // Ramp canvas, ready held high: back-to-back full transfer.
        push_beats(784);
        start_pulse();
        chk("busy_stream", Busy, 1);
        wait_done(1);
        chk("ramp_sum", pix_sum, 306936);
        chk("ramp_cycles", done_cyc - start_cyc, 784);
        chk("idle_busy", Busy, 0);

        // Saturation: all pixels above the limit.
        set_const(16'd3000);
        push_beats(784);
        start_pulse();
        wait_done(2);
        chk("sat_sum", pix_sum, 1604848);

        // Clamp boundaries around the limit.
        canvas[0][0] = 16'd2047;
        canvas[1][0] = 16'd2048;
        canvas[2][0] = 16'hFFFF;
        canvas[3][0] = 16'd2046;
        canvas[4][0] = 16'd0;
        push_beats(784);
        start_pulse();
        wait_done(3);
        chk("bound_sum", pix_sum, 1602800);

        // Abort at index 100: no Done, sum untouched, restart from 0.
        set_ramp();
        push_beats(100);
        start_pulse();
        wait_index(10'd100, "abort_reach");
        Abort = 1'b1;
        tick;
        Abort = 1'b0;
        chk("abort_valid", pix_valid, 0);
        chk("abort_busy", Busy, 0);
        tick;
        tick;
        tick;
        chk("abort_no_done", done_cnt, 3);
        chk("abort_sum", pix_sum, 1602800);
        chk("abort_sb", sb.size(), 0);
        push_beats(784);
        start_pulse();
        wait_done(4);
        chk("restart_sum", pix_sum, 306936);

        // Stalls: ready follows a fixed irregular pattern.
        set_const(16'd0);
        for (int i = 0; i < 28; i++) canvas[i][i] = 16'(100 + i);
        canvas[27][27] = 16'd4000;
        push_beats(784);
        start_pulse();
        n = 0;
        while (done_cnt < 5 && n < 5000) begin
            pix_ready = pat[n % 11];
            tick;
            n++;
        end
        pix_ready = 1'b1;
        chk("stall_done", done_cnt, 5);
        chk("stall_sb", sb.size(), 0);
        chk("stall_sum", pix_sum, 2047 + 100 * 27 + 351);
        tick;
        tick;
        chk("stall_done_once", done_cnt, 5);

        // Start ignored mid-stream, then async reset at index 500.
        set_ramp();
        push_beats(500);
        start_pulse();
        wait_index(10'd200, "reach_200");
        Start = 1'b1;
        tick;
        Start = 1'b0;
        wait_index(10'd500, "reach_500");
        #2;
        Reset = 1'b1;
        #1;
        chk("arst_valid", pix_valid, 0);
        chk("arst_index", pix_index, 0);
        chk("arst_last", pix_last, 0);
        chk("arst_busy", Busy, 0);
        chk("arst_done", Done, 0);
        chk("arst_sum", pix_sum, 0);
        tick;
        Reset = 1'b0;
        dc = done_cnt;
        tick;
        tick;
        chk("arst_sb", sb.size(), 0);
        chk("arst_no_done", done_cnt, dc);
        chk("arst_idle", Busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/canvas_streamer.md
CANVAS_STREAMER -- requirements
Module: canvas_streamer

Interface
REQ-001 Parameter DIM, default 28, canvas edge length in blocks.
REQ-002 Parameter PIX_W, default 16, pixel width in bits.
REQ-003 Parameter SAT_MAX, default 2047, maximum legal pixel value.
REQ-004 frame_clk  input  1  clock; all state updates on rising edge.
REQ-005 Reset  input  1  reset, asynchronous, active-high.
REQ-006 Start  input  1  request one full canvas transfer; sampled in IDLE only.
REQ-007 Abort  input  1  synchronous cancel of an in-progress transfer.
REQ-008 canvas  input  PIX_W x DIM x DIM  pixel array, indexed [X][Y], from the canvas editor.
REQ-009 pix_ready  input  1  downstream (NN input layer) accepts the current pixel.
REQ-010 pix_valid  output  1  pix_data, pix_index and pix_last are valid.
REQ-011 pix_data  output  PIX_W  pixel value, clamped to SAT_MAX.
REQ-012 pix_index  output  10  linear index y*DIM+x, 0..DIM*DIM-1.
REQ-013 pix_last  output  1  current pixel is index DIM*DIM-1.
REQ-014 Busy  output  1  high in STREAM; upstream gates its edit enable (Run) with !Busy.
REQ-015 Done  output  1  one-cycle pulse after the last pixel is accepted.
REQ-016 pix_sum  output  21  sum of all accepted clamped pixels of the last complete transfer.

Function
REQ-017 FSM states: IDLE, STREAM, FINISH.
REQ-018 IDLE: Start=1 -> STREAM, with x=0, y=0, running sum=0, pix_valid=1 at the next cycle (latency 1 cycle).
REQ-019 Scan order: row-major; x is the inner counter 0..DIM-1, y the outer; pix_data=canvas[x][y].
REQ-020 Acceptance: a pixel is transferred on a rising edge where pix_valid=1 and pix_ready=1.
REQ-021 While pix_valid=1 and pix_ready=0, pix_data, pix_index and pix_last are held stable.
REQ-022 On acceptance, x wraps DIM-1 -> 0 and increments y; the running sum adds the clamped pixel.
REQ-023 Clamp: pix_data=SAT_MAX when the canvas value exceeds SAT_MAX; otherwise the canvas value unchanged.
REQ-024 Back-to-back: with pix_ready held high, one pixel is accepted every cycle; a full transfer takes DIM*DIM cycles.
REQ-025 Acceptance of index DIM*DIM-1 -> FINISH; pix_valid=0; pix_sum loads the final running sum.
REQ-026 FINISH: Done=1 for exactly one cycle -> IDLE.
REQ-027 Start is ignored outside IDLE; Start held high in IDLE after FINISH begins a new transfer.
REQ-028 Abort=1 in STREAM -> IDLE on the next edge; pix_valid=0; no Done pulse; pix_sum unchanged. Abort has priority over acceptance.
REQ-029 Abort in IDLE or FINISH has no effect.
REQ-030 pix_data is combinationally selected from the live canvas at the registered (x,y); the canvas is frozen while Busy=1 (REQ-014).

Reset
REQ-031 Reset=1 forces state IDLE, x=y=0, running sum=0, pix_sum=0, pix_valid=0, pix_last=0, Busy=0, Done=0, pix_index=0, immediately and regardless of clock.
REQ-032 Reset during STREAM discards the transfer; no Done pulse is produced.

Structure
REQ-033 A shared package holds the FSM state enum, DIM, PIX_W, SAT_MAX and the index width constant.
REQ-034 One sub-module, pix_clamp (combinational saturation to SAT_MAX), is instantiated once.
REQ-035 Counters, FSM and sum accumulator are in canvas_streamer itself; no memory macro is used.

Verification
REQ-036 Canvas with canvas[x][y]=y*28+x, pix_ready=1, Start pulse -> 784 beats, pix_index 0..783 consecutive, data equal to index, pix_last only at 783, Done 1 cycle after the last beat, pix_sum=306936.
REQ-037 All pixels 3000 -> every pix_data=2047, pix_sum=1604848.
REQ-038 pix_ready toggling 1-0-0-1 pseudo-randomly -> the stalled beat is held stable, no index is skipped or duplicated, Done exactly once.
REQ-039 Abort at pix_index=100 -> IDLE next cycle, pix_valid=0, no Done, pix_sum keeps its previous value; a subsequent Start restarts at index 0.
REQ-040 Reset asserted asynchronously at pix_index=500 -> all outputs at REQ-031 values before the next edge; Start during STREAM is ignored.
